// File: rtl/pq_request_scheduler_pkg.sv
// Shared types for the priority-queue request scheduler: key type, reserved key, FSM and command encodings.
package pq_pkg;

    localparam int unsigned PQ_DATA_WIDTH = 16;

    typedef logic [PQ_DATA_WIDTH-1:0] key_t;

    // All-ones is accepted on push but downstream it reads as an empty slot.
    localparam key_t KEY_MAX = '1;

    typedef enum logic {
        IDLE,
        SETTLE
    } sched_state_e;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_PUSH,
        CMD_POP,
        CMD_REPLACE
    } cmd_e;

endpackage

// File: rtl/pq_request_scheduler_resp_reg.sv
// One-entry valid/ready holding register for popped keys; data is frozen while valid and not ready.
module pq_resp_reg #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_free
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Slot can take a new key when empty or draining this cycle.
    assign o_free  = ~r_valid | i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pq_request_scheduler.sv
// Issues spaced enqueue/dequeue/replace commands to the systolic min-queue and returns popped keys.
// Optional statistics counters are enabled by defining PQ_SCHED_STATS_EN.
module pq_request_scheduler
    import pq_pkg::*;
#(
    parameter int unsigned QUEUE_SIZE    = 8,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  s_push_valid,
    output logic                  s_push_ready,
    input  logic [DATA_WIDTH-1:0] s_push_data,
    input  logic                  s_pop_valid,
    output logic                  s_pop_ready,
    output logic                  m_pop_valid,
    input  logic                  m_pop_ready,
    output logic [DATA_WIDTH-1:0] m_pop_data,
    output logic                  q_wrt,
    output logic                  q_read,
    output logic [DATA_WIDTH-1:0] q_data,
    input  logic                  q_full,
    input  logic                  q_empty,
    input  logic [DATA_WIDTH-1:0] q_head
`ifdef PQ_SCHED_STATS_EN
    ,
    output logic [31:0]           o_push_cnt,
    output logic [31:0]           o_pop_cnt,
    output logic [31:0]           o_replace_cnt,
    output logic [31:0]           o_stall_cnt
`endif
);

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || QUEUE_SIZE < 1) begin : g_bad_cfg
        $error("pq_request_scheduler: illegal SETTLE_CYCLES or QUEUE_SIZE");
    end

    sched_state_e          r_state;
    sched_state_e          w_state_next;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_next;
    logic                  w_pop_ok;
    logic                  w_push_ok;
    logic                  w_resp_free;
    cmd_e                  w_cmd;
    logic                  r_wrt;
    logic                  r_read;
    logic [DATA_WIDTH-1:0] r_q_data;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_pop_ok     = 1'b0;
        w_push_ok    = 1'b0;
        w_cmd        = CMD_NONE;
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                w_pop_ok  = s_pop_valid & ~q_empty & w_resp_free;
                // A full queue only takes a push as the second half of a replace.
                w_push_ok = s_push_valid & (~q_full | w_pop_ok);
                if (w_push_ok | w_pop_ok) begin
                    w_state_next = SETTLE;
                    w_cnt_next   = CNT_LOAD;
                end
            end
            SETTLE: begin
                if (r_cnt == '0) w_state_next = IDLE;
                else             w_cnt_next   = r_cnt - 4'd1;
            end
            default: w_state_next = IDLE;
        endcase
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_cmd = CMD_PUSH;
            2'b01:   w_cmd = CMD_POP;
            2'b11:   w_cmd = CMD_REPLACE;
            default: w_cmd = CMD_NONE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wrt    <= 1'b0;
            r_read   <= 1'b0;
            r_q_data <= '0;
        end else begin
            r_wrt  <= (w_cmd == CMD_PUSH) || (w_cmd == CMD_REPLACE);
            r_read <= (w_cmd == CMD_POP)  || (w_cmd == CMD_REPLACE);
            if (w_push_ok) r_q_data <= s_push_data;
        end
    end

    // Head is captured before the command lands, so a replace returns the old minimum.
    pq_resp_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_resp (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_load  (w_pop_ok),
        .i_data  (q_head),
        .i_ready (m_pop_ready),
        .o_valid (m_pop_valid),
        .o_data  (m_pop_data),
        .o_free  (w_resp_free)
    );

    assign s_push_ready = w_push_ok;
    assign s_pop_ready  = w_pop_ok;
    assign q_wrt        = r_wrt;
    assign q_read       = r_read;
    assign q_data       = r_q_data;

`ifdef PQ_SCHED_STATS_EN
    logic [31:0] r_push_cnt;
    logic [31:0] r_pop_cnt;
    logic [31:0] r_replace_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = (s_push_valid & ~w_push_ok) | (s_pop_valid & ~w_pop_ok);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_push_cnt    <= '0;
            r_pop_cnt     <= '0;
            r_replace_cnt <= '0;
            r_stall_cnt   <= '0;
        end else begin
            if (w_cmd == CMD_PUSH    && r_push_cnt    != '1) r_push_cnt    <= r_push_cnt + 32'd1;
            if (w_cmd == CMD_POP     && r_pop_cnt     != '1) r_pop_cnt     <= r_pop_cnt + 32'd1;
            if (w_cmd == CMD_REPLACE && r_replace_cnt != '1) r_replace_cnt <= r_replace_cnt + 32'd1;
            if (w_stall              && r_stall_cnt   != '1) r_stall_cnt   <= r_stall_cnt + 32'd1;
        end
    end

    assign o_push_cnt    = r_push_cnt;
    assign o_pop_cnt     = r_pop_cnt;
    assign o_replace_cnt = r_replace_cnt;
    assign o_stall_cnt   = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pq_request_scheduler.sv
// Self-checking bench for pq_request_scheduler with a behavioural min-queue downstream and a reference model.
module tb_pq_request_scheduler;

    localparam int QS = 8;
    localparam int DW = 16;
    localparam int S  = 2;

    logic          CLK = 1'b0;
    logic          RST;
    logic          s_push_valid;
    logic          s_push_ready;
    logic [DW-1:0] s_push_data;
    logic          s_pop_valid;
    logic          s_pop_ready;
    logic          m_pop_valid;
    logic          m_pop_ready;
    logic [DW-1:0] m_pop_data;
    logic          q_wrt;
    logic          q_read;
    logic [DW-1:0] q_data;
    logic          q_full;
    logic          q_empty;
    logic [DW-1:0] q_head;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    pq_request_scheduler #(
        .QUEUE_SIZE   (QS),
        .DATA_WIDTH   (DW),
        .SETTLE_CYCLES(S)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .s_push_valid(s_push_valid),
        .s_push_ready(s_push_ready),
        .s_push_data (s_push_data),
        .s_pop_valid (s_pop_valid),
        .s_pop_ready (s_pop_ready),
        .m_pop_valid (m_pop_valid),
        .m_pop_ready (m_pop_ready),
        .m_pop_data  (m_pop_data),
        .q_wrt       (q_wrt),
        .q_read      (q_read),
        .q_data      (q_data),
        .q_full      (q_full),
        .q_empty     (q_empty),
        .q_head      (q_head)
    );

    // Downstream min-queue: commits strobed commands at the clock edge, pop before push.
    logic [DW-1:0] env_q[$];
    always @(posedge CLK or posedge RST) begin
        int i;
        if (RST) begin
            env_q.delete();
        end else begin
            if (q_read && env_q.size() > 0) void'(env_q.pop_front());
            if (q_wrt) begin
                i = 0;
                while (i < env_q.size() && env_q[i] <= q_data) i++;
                env_q.insert(i, q_data);
            end
        end
        q_head  <= (env_q.size() > 0) ? env_q[0] : '1;
        q_empty <= (env_q.size() == 0);
        q_full  <= (env_q.size() >= QS);
    end

    task automatic push_one(input int key, output bit ok);
        ok = 0;
        s_push_data  = DW'(key);
        s_push_valid = 1'b1;
        for (int c = 0; c < 30 && !ok; c++) begin
            @(negedge CLK);
            ok = s_push_ready;
            @(posedge CLK); #1;
        end
        s_push_valid = 1'b0;
    endtask

    task automatic pop_one(output logic [DW-1:0] d, output bit ok);
        ok = 0;
        m_pop_ready = 1'b1;
        s_pop_valid = 1'b1;
        for (int c = 0; c < 30 && !ok; c++) begin
            @(negedge CLK);
            ok = s_pop_ready;
            @(posedge CLK); #1;
        end
        s_pop_valid = 1'b0;
        @(negedge CLK);
        d  = m_pop_data;
        ok = ok && m_pop_valid;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        s_push_valid = 0; s_pop_valid = 0; m_pop_ready = 0; s_push_data = '0;
        repeat (3) @(negedge CLK);
        checks++; if (m_pop_valid !== 1'b0) begin errors++; $display("FAIL reset_m_pop_valid: got %b expected 0", m_pop_valid); end
        checks++; if (m_pop_data !== '0) begin errors++; $display("FAIL reset_m_pop_data: got %0d expected 0", m_pop_data); end
        checks++; if (q_wrt !== 1'b0 || q_read !== 1'b0) begin errors++; $display("FAIL reset_strobes: got wrt=%b read=%b expected 0/0", q_wrt, q_read); end
        checks++; if (q_data !== '0) begin errors++; $display("FAIL reset_q_data: got %0d expected 0", q_data); end
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic test_push_spacing();
        int keys[3] = '{5, 3, 9};
        int wc[3];
        int ac[3];
        int idx = 0;
        int nw = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge CLK); #1;
            s_push_valid = (idx < 3);
            s_push_data  = DW'(keys[(idx < 3) ? idx : 0]);
            @(negedge CLK);
            if (q_wrt) begin
                if (nw < 3) begin
                    wc[nw] = c;
                    checks++; if (q_data !== DW'(keys[nw])) begin errors++; $display("FAIL spacing_q_data: got %0d expected %0d", q_data, keys[nw]); end
                end
                nw++;
            end
            if (s_push_valid && s_push_ready && idx < 3) begin ac[idx] = c; idx++; end
        end
        s_push_valid = 1'b0;
        checks++; if (nw != 3) begin errors++; $display("FAIL spacing_pulse_count: got %0d expected 3", nw); end
        if (nw == 3 && idx == 3) begin
            checks++; if (wc[0] != ac[0] + 1) begin errors++; $display("FAIL spacing_latency: got %0d expected %0d", wc[0] - ac[0], 1); end
            checks++; if (wc[1] - wc[0] != S + 1) begin errors++; $display("FAIL spacing_gap1: got %0d expected %0d", wc[1] - wc[0], S + 1); end
            checks++; if (wc[2] - wc[1] != S + 1) begin errors++; $display("FAIL spacing_gap2: got %0d expected %0d", wc[2] - wc[1], S + 1); end
            checks++; if (ac[1] - ac[0] != S + 1) begin errors++; $display("FAIL spacing_ready_low: got %0d expected %0d", ac[1] - ac[0], S + 1); end
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_pop_order();
        int exp[3] = '{3, 5, 9};
        int nacc = 0;
        int nget = 0;
        int wide = 0;
        logic prev_read = 1'b0;
        m_pop_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge CLK); #1;
            s_pop_valid = (nacc < 3);
            @(negedge CLK);
            if (q_read && prev_read) wide++;
            prev_read = q_read;
            if (m_pop_valid && m_pop_ready) begin
                if (nget < 3) begin
                    checks++; if (m_pop_data !== DW'(exp[nget])) begin errors++; $display("FAIL pop_order_%0d: got %0d expected %0d", nget, m_pop_data, exp[nget]); end
                end
                nget++;
            end
            if (s_pop_valid && s_pop_ready) nacc++;
        end
        s_pop_valid = 1'b0;
        checks++; if (nget != 3) begin errors++; $display("FAIL pop_count: got %0d expected 3", nget); end
        checks++; if (wide != 0) begin errors++; $display("FAIL pop_strobe_width: got %0d wide strobes expected 0", wide); end
        @(posedge CLK); #1;
    endtask

    task automatic test_full_replace();
        bit ok;
        int hi = 0;
        int both = 0;
        logic [DW-1:0] d;
        for (int k = 10; k < 18; k++) begin
            push_one(k, ok);
            checks++; if (!ok) begin errors++; $display("FAIL fill_push_%0d: got timeout expected accept", k); end
        end
        repeat (S + 2) @(posedge CLK); #1;
        s_push_data = DW'(1); s_push_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (s_push_ready || q_wrt) hi++;
            @(posedge CLK); #1;
        end
        checks++; if (hi != 0) begin errors++; $display("FAIL full_push_blocked: got %0d ready cycles expected 0", hi); end
        m_pop_ready = 1'b1; s_pop_valid = 1'b1; ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge CLK);
            ok = s_push_ready || s_pop_ready;
            both = (s_push_ready && s_pop_ready);
            @(posedge CLK); #1;
        end
        s_push_valid = 1'b0; s_pop_valid = 1'b0;
        checks++; if (both != 1) begin errors++; $display("FAIL replace_accept: got %0d expected 1", both); end
        @(negedge CLK);
        checks++; if (q_wrt !== 1'b1 || q_read !== 1'b1 || q_data !== DW'(1)) begin
            errors++; $display("FAIL replace_cmd: got wrt=%b read=%b data=%0d expected 1/1/1", q_wrt, q_read, q_data); end
        checks++; if (m_pop_valid !== 1'b1 || m_pop_data !== DW'(10)) begin
            errors++; $display("FAIL replace_old_head: got v=%b d=%0d expected 1/10", m_pop_valid, m_pop_data); end
        @(posedge CLK); #1;
        pop_one(d, ok);
        checks++; if (!ok || d !== DW'(1)) begin errors++; $display("FAIL replace_next_pop: got %0d expected 1", d); end
        for (int k = 11; k < 18; k++) begin
            pop_one(d, ok);
            checks++; if (!ok || d !== DW'(k)) begin errors++; $display("FAIL drain_pop: got %0d expected %0d", d, k); end
        end
        repeat (S + 2) @(posedge CLK); #1;
    endtask

    task automatic test_empty_pair();
        bit ok = 0;
        logic pr = 1'b1;
        m_pop_ready = 1'b1;
        s_push_data = DW'(7); s_push_valid = 1'b1; s_pop_valid = 1'b1;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge CLK);
            ok = s_push_ready;
            pr = s_pop_ready;
            @(posedge CLK); #1;
        end
        s_push_valid = 1'b0;
        checks++; if (!ok || pr !== 1'b0) begin errors++; $display("FAIL empty_pair_accept: got push=%b pop=%b expected 1/0", ok, pr); end
        @(negedge CLK);
        checks++; if (q_wrt !== 1'b1 || q_read !== 1'b0) begin errors++; $display("FAIL empty_pair_cmd: got wrt=%b read=%b expected 1/0", q_wrt, q_read); end
        ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (c > 0) @(negedge CLK);
            ok = s_pop_ready;
            @(posedge CLK); #1;
        end
        s_pop_valid = 1'b0;
        @(negedge CLK);
        checks++; if (!ok || m_pop_valid !== 1'b1 || m_pop_data !== DW'(7)) begin
            errors++; $display("FAIL empty_pair_pop: got v=%b d=%0d expected 1/7", m_pop_valid, m_pop_data); end
        @(posedge CLK); #1;
        repeat (S + 2) @(posedge CLK); #1;
    endtask

    task automatic test_hold_reset();
        bit ok;
        push_one(4, ok);
        push_one(6, ok);
        repeat (S + 2) @(posedge CLK); #1;
        m_pop_ready = 1'b0; s_pop_valid = 1'b1; ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge CLK);
            ok = s_pop_ready;
            @(posedge CLK); #1;
        end
        checks++; if (!ok) begin errors++; $display("FAIL hold_first_pop: got timeout expected accept"); end
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            checks++; if (s_pop_ready !== 1'b0 || m_pop_valid !== 1'b1 || m_pop_data !== DW'(4)) begin
                errors++; $display("FAIL hold_stable: got rdy=%b v=%b d=%0d expected 0/1/4", s_pop_ready, m_pop_valid, m_pop_data); end
        end
        @(posedge CLK); #3;
        RST = 1'b1;
        #1;
        checks++; if (m_pop_valid !== 1'b0 || m_pop_data !== '0 || q_wrt !== 1'b0 || q_read !== 1'b0) begin
            errors++; $display("FAIL async_reset: got v=%b d=%0d wrt=%b read=%b expected 0/0/0/0", m_pop_valid, m_pop_data, q_wrt, q_read); end
        s_pop_valid = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic test_random();
        logic [DW-1:0] ref_q[$];
        logic          ref_rv = 1'b0;
        logic [DW-1:0] ref_rd = '0;
        logic          exp_wrt = 1'b0;
        logic          exp_read = 1'b0;
        logic [DW-1:0] exp_qd = '0;
        int            next_ok = 0;
        logic          e_pop, e_push, idle;
        int            i;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(posedge CLK); #1;
            s_push_valid = 1'($urandom_range(0, 1));
            s_pop_valid  = 1'($urandom_range(0, 1));
            s_push_data  = DW'($urandom);
            m_pop_ready  = ($urandom_range(0, 3) != 0);
            @(negedge CLK);
            idle   = (cyc >= next_ok);
            e_pop  = idle && s_pop_valid && ref_q.size() != 0 && (!ref_rv || m_pop_ready);
            e_push = idle && s_push_valid && (ref_q.size() < QS || e_pop);
            checks++; if (s_pop_ready !== e_pop) begin errors++; $display("FAIL rnd_pop_ready@%0d: got %b expected %b", cyc, s_pop_ready, e_pop); end
            checks++; if (s_push_ready !== e_push) begin errors++; $display("FAIL rnd_push_ready@%0d: got %b expected %b", cyc, s_push_ready, e_push); end
            checks++; if (m_pop_valid !== ref_rv) begin errors++; $display("FAIL rnd_m_valid@%0d: got %b expected %b", cyc, m_pop_valid, ref_rv); end
            if (ref_rv) begin
                checks++; if (m_pop_data !== ref_rd) begin errors++; $display("FAIL rnd_m_data@%0d: got %0d expected %0d", cyc, m_pop_data, ref_rd); end
            end
            checks++; if (q_wrt !== exp_wrt || q_read !== exp_read) begin
                errors++; $display("FAIL rnd_strobes@%0d: got wrt=%b read=%b expected %b/%b", cyc, q_wrt, q_read, exp_wrt, exp_read); end
            if (exp_wrt) begin
                checks++; if (q_data !== exp_qd) begin errors++; $display("FAIL rnd_q_data@%0d: got %0d expected %0d", cyc, q_data, exp_qd); end
            end
            exp_wrt  = e_push;
            exp_read = e_pop;
            if (e_push) exp_qd = s_push_data;
            if (ref_rv && m_pop_ready) ref_rv = 1'b0;
            if (e_pop) begin
                ref_rd = ref_q.pop_front();
                ref_rv = 1'b1;
            end
            if (e_push) begin
                i = 0;
                while (i < ref_q.size() && ref_q[i] <= s_push_data) i++;
                ref_q.insert(i, s_push_data);
            end
            if (e_pop || e_push) next_ok = cyc + S + 1;
        end
        s_push_valid = 1'b0; s_pop_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_push_spacing();
        test_pop_order();
        test_full_replace();
        test_empty_pair();
        test_hold_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
